// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel strobe into the generator, position/sync/pulse outputs back out.
interface video_timing_if;
    logic       pix_en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_en,
        output pixel_x, pixel_y, active, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  pixel_x, pixel_y, active, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters with registered active, sync and start pulses.
module video_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    video_timing_if.master vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Position counters are 10 bits wide, so larger rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("video_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_LIM = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q;
    logic       frame_start_q;

    // Levels are decoded from the next position so they land in the same cycle as it.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
        active_d = ({1'b0, x_d} < H_ACT_LIM) && ({1'b0, y_d} < V_ACT_LIM);
        hsync_d  = ({1'b0, x_d} >= HS_BEG && {1'b0, x_d} < HS_END) ? H_POL : ~H_POL;
        vsync_d  = ({1'b0, y_d} >= VS_BEG && {1'b0, y_d} < VS_END) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            active_q      <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vid.pix_en) begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= (x_d == '0);
            frame_start_q <= (x_d == '0) && (y_d == '0);
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vid.pixel_x     = x_q;
    assign vid.pixel_y     = y_q;
    assign vid.active      = active_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: three instances (default, small raster, overridden polarity) against a linear-index raster model.
module tb_video_timing;
    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        bit hpol; bit vpol;
    } tcfg_t;

    localparam tcfg_t CFG_DEF = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, hpol:1'b0, vpol:1'b0};
    localparam tcfg_t CFG_SML = '{ha:16, hfp:4, hs:6, hbp:6, va:12, vfp:2, vs:2, vbp:3, hpol:1'b0, vpol:1'b1};
    localparam tcfg_t CFG_OVR = '{ha:480, hfp:8, hs:32, hbp:40, va:480, vfp:10, vs:2, vbp:33, hpol:1'b1, vpol:1'b1};

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] en  = 3'b000;
    always #5 clk = ~clk;

    video_timing_if vid_def ();
    video_timing_if vid_sml ();
    video_timing_if vid_ovr ();
    assign vid_def.pix_en = en[0];
    assign vid_sml.pix_en = en[1];
    assign vid_ovr.pix_en = en[2];

    video_timing u_def (.clk(clk), .rst(rst), .vid(vid_def));

    video_timing #(
        .H_ACTIVE(CFG_SML.ha), .H_FP(CFG_SML.hfp), .H_SYNC(CFG_SML.hs), .H_BP(CFG_SML.hbp),
        .V_ACTIVE(CFG_SML.va), .V_FP(CFG_SML.vfp), .V_SYNC(CFG_SML.vs), .V_BP(CFG_SML.vbp),
        .H_POL(CFG_SML.hpol), .V_POL(CFG_SML.vpol)
    ) u_sml (.clk(clk), .rst(rst), .vid(vid_sml));

    video_timing #(
        .H_ACTIVE(480), .H_FP(8), .H_SYNC(32), .H_BP(40), .H_POL(1'b1), .V_POL(1'b1)
    ) u_ovr (.clk(clk), .rst(rst), .vid(vid_ovr));

    // reference model: each raster is a linear pixel index n in 0..H_TOTAL*V_TOTAL-1
    int   n_m  [3];
    logic ls_m [3];
    logic fs_m [3];
    int   checks = 0;
    int   errors = 0;

    function automatic tcfg_t cfg_of(input int i);
        case (i)
            0:       return CFG_DEF;
            1:       return CFG_SML;
            default: return CFG_OVR;
        endcase
    endfunction

    function automatic int htot(input tcfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int vtot(input tcfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    // {x, y, active, hsync, vsync, line_start, frame_start}
    function automatic logic [24:0] exp_vec(input int i);
        tcfg_t c;
        int    x, y;
        logic  act, hs, vs;
        c   = cfg_of(i);
        x   = n_m[i] % htot(c);
        y   = n_m[i] / htot(c);
        act = (x < c.ha) && (y < c.va);
        hs  = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
        vs  = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
        return {x[9:0], y[9:0], act, hs, vs, ls_m[i], fs_m[i]};
    endfunction

    function automatic logic [24:0] dut_vec(input int i);
        case (i)
            0: return {vid_def.pixel_x, vid_def.pixel_y, vid_def.active, vid_def.hsync,
                       vid_def.vsync, vid_def.line_start, vid_def.frame_start};
            1: return {vid_sml.pixel_x, vid_sml.pixel_y, vid_sml.active, vid_sml.hsync,
                       vid_sml.vsync, vid_sml.line_start, vid_sml.frame_start};
            default: return {vid_ovr.pixel_x, vid_ovr.pixel_y, vid_ovr.active, vid_ovr.hsync,
                             vid_ovr.vsync, vid_ovr.line_start, vid_ovr.frame_start};
        endcase
    endfunction

    // driver: advance one clock and apply the same edge to the model
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tcfg_t c;
            int    tot;
            c   = cfg_of(i);
            tot = htot(c) * vtot(c);
            if (rst) begin
                n_m[i]  = tot - 1;
                ls_m[i] = 1'b0;
                fs_m[i] = 1'b0;
            end else if (en[i]) begin
                n_m[i]  = (n_m[i] + 1) % tot;
                ls_m[i] = (n_m[i] % htot(c)) == 0;
                fs_m[i] = (n_m[i] == 0);
            end else begin
                ls_m[i] = 1'b0;
                fs_m[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [24:0] want;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en = 3'($urandom_range(0, 7));
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL reset_model dut%0d got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
        want = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (dut_vec(0) !== want) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", dut_vec(0), want);
        end
    endtask

    task automatic test_first_edge();
        logic [24:0] want;
        rst = 1'b0;
        en  = 3'b111;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL first_edge_model dut%0d got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
            want = (k == 0) ? {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}
                            : {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            checks++;
            if (dut_vec(0) !== want) begin
                errors++;
                $display("FAIL first_edge cycle %0d got %h expected %h", k + 1, dut_vec(0), want);
            end
        end
    endtask

    task automatic test_full_frame();
        int tot, ls_cnt, fs_cnt, act_cnt, hs_cnt, vs_cnt;
        tot = htot(CFG_SML) * vtot(CFG_SML);
        ls_cnt = 0; fs_cnt = 0; act_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        rst = 1'b1;
        en  = 3'b111;
        tick();
        rst = 1'b0;
        for (int k = 0; k < tot; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL frame_model dut%0d got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
            ls_cnt  += int'(vid_sml.line_start);
            fs_cnt  += int'(vid_sml.frame_start);
            act_cnt += int'(vid_sml.active);
            hs_cnt  += int'(vid_sml.hsync == CFG_SML.hpol);
            vs_cnt  += int'(vid_sml.vsync == CFG_SML.vpol);
        end
        checks++;
        if (ls_cnt != vtot(CFG_SML)) begin
            errors++;
            $display("FAIL frame_line_starts got %0d expected %0d", ls_cnt, vtot(CFG_SML));
        end
        checks++;
        if (fs_cnt != 1) begin
            errors++;
            $display("FAIL frame_frame_starts got %0d expected 1", fs_cnt);
        end
        checks++;
        if (act_cnt != CFG_SML.ha * CFG_SML.va) begin
            errors++;
            $display("FAIL frame_active_count got %0d expected %0d", act_cnt, CFG_SML.ha * CFG_SML.va);
        end
        checks++;
        if (hs_cnt != CFG_SML.hs * vtot(CFG_SML)) begin
            errors++;
            $display("FAIL frame_hsync_count got %0d expected %0d", hs_cnt, CFG_SML.hs * vtot(CFG_SML));
        end
        checks++;
        if (vs_cnt != CFG_SML.vs * htot(CFG_SML)) begin
            errors++;
            $display("FAIL frame_vsync_count got %0d expected %0d", vs_cnt, CFG_SML.vs * htot(CFG_SML));
        end
    endtask

    task automatic test_boundaries();
        int tot, ht, mx, my;
        tot = htot(CFG_SML) * vtot(CFG_SML);
        ht  = htot(CFG_SML);
        en  = 3'b111;
        for (int k = 0; k < tot; k++) begin
            tick();
            mx = n_m[1] % ht;
            my = n_m[1] / ht;
            if (mx == CFG_SML.ha - 1 && my == CFG_SML.va - 1) begin
                checks++;
                if (vid_sml.active !== 1'b1) begin
                    errors++;
                    $display("FAIL bound_last_active got %b expected 1", vid_sml.active);
                end
            end
            if (mx == CFG_SML.ha && my == CFG_SML.va - 1) begin
                checks++;
                if (vid_sml.active !== 1'b0) begin
                    errors++;
                    $display("FAIL bound_first_blank got %b expected 0", vid_sml.active);
                end
            end
            if (mx == 0 && my == CFG_SML.va) begin
                checks++;
                if ({vid_sml.active, vid_sml.line_start, vid_sml.frame_start} !== 3'b010) begin
                    errors++;
                    $display("FAIL bound_first_vblank got %b expected 010",
                             {vid_sml.active, vid_sml.line_start, vid_sml.frame_start});
                end
            end
            if (n_m[1] == 0) begin
                checks++;
                if ({vid_sml.pixel_x, vid_sml.pixel_y, vid_sml.frame_start, vid_sml.line_start} !== 22'h3) begin
                    errors++;
                    $display("FAIL bound_frame_wrap got x=%0d y=%0d fs=%b ls=%b expected 0 0 1 1",
                             vid_sml.pixel_x, vid_sml.pixel_y, vid_sml.frame_start, vid_sml.line_start);
                end
            end
            if (n_m[0] == 639 || n_m[0] == 640) begin
                checks++;
                if (vid_def.active !== (n_m[0] == 639)) begin
                    errors++;
                    $display("FAIL bound_def_active at x=%0d got %b", n_m[0], vid_def.active);
                end
            end
            if (n_m[0] == 655 || n_m[0] == 656) begin
                checks++;
                if (vid_def.hsync !== (n_m[0] == 655)) begin
                    errors++;
                    $display("FAIL bound_def_hsync at x=%0d got %b", n_m[0], vid_def.hsync);
                end
            end
        end
    endtask

    task automatic test_strobe();
        logic [3:0] pat;
        logic [3:0] want_x0;
        logic [3:0] want_fs;
        pat     = 4'b1001;
        want_x0 = 4'b1110;
        want_fs = 4'b1000;
        rst = 1'b1;
        en  = 3'b111;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            en = {3{pat[3 - s]}};
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL strobe_model dut%0d got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (vid_sml.pixel_x !== (want_x0[3 - s] ? 10'd0 : 10'd1) || vid_sml.pixel_y !== 10'd0 ||
                vid_sml.frame_start !== want_fs[3 - s] || vid_sml.line_start !== want_fs[3 - s]) begin
                errors++;
                $display("FAIL strobe_step %0d got x=%0d y=%0d fs=%b ls=%b", s, vid_sml.pixel_x,
                         vid_sml.pixel_y, vid_sml.frame_start, vid_sml.line_start);
            end
        end
    endtask

    task automatic test_random_strobe();
        int duty [3];
        for (int i = 0; i < 3; i++) duty[i] = $urandom_range(10, 90);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 3; i++) en[i] = ($urandom_range(0, 99) < duty[i]);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random_model dut%0d got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int          tot, target;
        bit          found;
        logic [24:0] want;
        tot    = htot(CFG_SML) * vtot(CFG_SML);
        target = 10 * htot(CFG_SML) + 20;
        found  = 1'b0;
        en     = 3'b111;
        for (int k = 0; k < 2 * tot && !found; k++) begin
            tick();
            if (n_m[1] == target) found = 1'b1;
        end
        checks++;
        if (!found || dut_vec(1) !== exp_vec(1)) begin
            errors++;
            $display("FAIL mid_reset_reach got %h expected %h", dut_vec(1), exp_vec(1));
        end
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            rst = 1'b0;
            case (s)
                0:       want = {10'd31, 10'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
                1:       want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
                default: want = {10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            endcase
            checks++;
            if (dut_vec(1) !== want) begin
                errors++;
                $display("FAIL mid_reset step %0d got %h expected %h", s, dut_vec(1), want);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL mid_reset_model dut%0d got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_override();
        int hs_min, hs_max, x_max, wraps, prev_x, cx;
        hs_min = 1024; hs_max = -1; x_max = -1; wraps = 0; prev_x = -1;
        rst = 1'b1;
        en  = 3'b111;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3 * 560 + 10; k++) begin
            tick();
            checks++;
            if (dut_vec(2) !== exp_vec(2)) begin
                errors++;
                $display("FAIL override_model got %h expected %h", dut_vec(2), exp_vec(2));
            end
            cx = int'(vid_ovr.pixel_x);
            if (vid_ovr.hsync === 1'b1) begin
                if (cx < hs_min) hs_min = cx;
                if (cx > hs_max) hs_max = cx;
            end
            if (cx > x_max) x_max = cx;
            if (prev_x == 559) begin
                wraps++;
                checks++;
                if (cx != 0) begin
                    errors++;
                    $display("FAIL override_wrap got x=%0d expected 0", cx);
                end
            end
            prev_x = cx;
        end
        checks++;
        if (hs_min != 488 || hs_max != 519) begin
            errors++;
            $display("FAIL override_hsync_window got %0d..%0d expected 488..519", hs_min, hs_max);
        end
        checks++;
        if (x_max != 559 || wraps != 3) begin
            errors++;
            $display("FAIL override_h_total got max_x=%0d wraps=%0d expected 559 3", x_max, wraps);
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_full_frame();
        test_boundaries();
        test_strobe();
        test_random_strobe();
        test_mid_reset();
        test_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, 33, vertical back porch in lines.
REQ-009 SHALL have parameter H_POL, 0, hsync asserted level (0 = active-low).
REQ-010 SHALL have parameter V_POL, 0, vsync asserted level (0 = active-low).
REQ-011 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-012 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-013 SHALL have port pix_en  input  1  pixel strobe; timing advances only on edges where high.
REQ-014 SHALL have port pixel_x  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-015 SHALL have port pixel_y  output  10  current vertical position, 0..V_TOTAL-1.
REQ-016 SHALL have port active  output  1  high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE.
REQ-017 SHALL have port hsync  output  1  horizontal sync, polarity per H_POL.
REQ-018 SHALL have port vsync  output  1  vertical sync, polarity per V_POL.
REQ-019 SHALL have port line_start  output  1  one-clk pulse when position enters x=0.
REQ-020 SHALL have port frame_start  output  1  one-clk pulse when position enters (0,0).

Function
REQ-021 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525); both SHALL be <=1024, enforced by elaboration-time check.
REQ-022 SHALL, on each clk edge with pix_en=1, increment pixel_x; at pixel_x=H_TOTAL-1 wrap to 0 and increment pixel_y; at (H_TOTAL-1,V_TOTAL-1) wrap both to 0.
REQ-023 SHALL hold all position and level outputs unchanged on edges with pix_en=0.
REQ-024 SHALL drive every output from a register; active, hsync, vsync SHALL describe the same (pixel_x,pixel_y) presented in the same cycle (zero skew between outputs).
REQ-025 SHALL assert hsync when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751), else drive ~H_POL.
REQ-026 SHALL assert vsync when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491) for the whole line including blanking, else drive ~V_POL.
REQ-027 SHALL assert line_start for exactly one clk cycle following an enabled edge that moved pixel_x to 0; it SHALL deassert on the next edge regardless of pix_en.
REQ-028 SHALL assert frame_start under the same rule when the move is to (0,0); frame_start implies line_start in the same cycle.
REQ-029 SHALL never present pixel_x>=H_TOTAL or pixel_y>=V_TOTAL.
REQ-030 SHALL behave identically with pix_en tied high (one pixel per clk) and strobed at any duty cycle, apart from time scaling.

Reset
REQ-031 SHALL, when rst=1 at an edge, load pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524), active=0, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0, regardless of pix_en.
REQ-032 SHALL give rst priority over pix_en; reset asserted mid-frame SHALL abandon the frame immediately.
REQ-033 SHALL make the first enabled edge after rst release move to (0,0) with active=1 and frame_start=line_start=1.

Verification
REQ-034 Reset then pix_en=1 -> cycle 1: (0,0), active=1, frame_start=1, line_start=1, hsync=1, vsync=1; cycle 2: (1,0), pulses 0.
REQ-035 pix_en=1 for 800*525 cycles from (0,0) -> exactly 525 line_start, 1 frame_start per frame; hsync low for 96 clks per line at x=656..751; vsync low on lines 490..491 only; active count 307200.
REQ-036 Boundary: at (639,479) active=1; next (640,479) active=0; (799,479)->(0,480) active=0; (799,524)->(0,0) frame_start=1.
REQ-037 pix_en toggled 1,0,0,1 at (0,0) entry -> frame_start high one clk only; position holds during pix_en=0; advances to (1,0) on the next enabled edge.
REQ-038 rst asserted at (300,200) with pix_en=1 -> next cycle outputs equal REQ-031 values; after release, sequence restarts per REQ-033.
REQ-039 Override H_POL=1, V_POL=1, H_ACTIVE=480, H_FP=8, H_SYNC=32, H_BP=40 -> hsync high at x=488..519 only, idle low, H_TOTAL=560 wrap observed.
